writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Sits directly upstream of the multi-port register file.
- Collects results from NUM_SOURCES functional-unit result channels over valid/ready handshakes.
- Each cycle, picks up to NUM_WRITE_PORTS of them in round-robin order and drives the register-file write ports through one register stage.
- Guarantees no two enabled write ports target the same register in one cycle, and never enables a write to register 0.

Parameters:
REG_NUM, 32, number of architectural registers; ADDR_W = $clog2(REG_NUM)
DATA_WIDTH, 32, result/register width
NUM_WRITE_PORTS, 4, register-file write ports driven
NUM_SOURCES, 6, functional-unit result channels (must be >= NUM_WRITE_PORTS)

Ports:
clk  input  1  clock, all state on rising edge
rstN  input  1  asynchronous active-low reset
srcValid  input  NUM_SOURCES  per-source result valid
srcAddr  input  NUM_SOURCES*ADDR_W  destination register, source i at bits [i*ADDR_W +: ADDR_W]
srcData  input  NUM_SOURCES*DATA_WIDTH  result data, same packing
srcReady  output  NUM_SOURCES  per-source grant/accept (combinational)
writeEnable  output  NUM_WRITE_PORTS  registered write enables to register file
writeAddr  output  NUM_WRITE_PORTS*ADDR_W  registered write addresses
dataInputs  output  NUM_WRITE_PORTS*DATA_WIDTH  registered write data
grantCount  output  $clog2(NUM_WRITE_PORTS+1)  registered number of sources accepted last cycle (includes r0 drops)

Behaviour:
- Reset (rstN low, async): writeEnable=0, writeAddr=0, dataInputs=0, grantCount=0, rrPtr=0. srcReady=0 while rstN low. Release is synchronous to the next clk edge.
- Transfer: source i transfers on a cycle when srcValid[i] && srcReady[i]. A source holds valid/addr/data stable until accepted.
- Selection (combinational, per cycle):
  - Scan sources in order rrPtr, rrPtr+1, ... mod NUM_SOURCES, one full lap.
  - Grant a valid source if fewer than NUM_WRITE_PORTS are granted so far and its srcAddr does not equal the srcAddr of an earlier granted source with a nonzero address.
  - An address collision leaves the later source ungranted (srcReady=0). It retries next cycle.
  - srcAddr==0 always grants, subject to the port limit. It consumes a port slot but produces writeEnable=0 for that slot (result discarded).
- Port mapping: the k-th granted source in scan order uses write port k. Unused ports have writeEnable=0. Their writeAddr/dataInputs hold their previous values.
- Latency: exactly 1 cycle, accept edge to writeEnable/writeAddr/dataInputs valid. Outputs are registered only; no combinational path from src* to write ports.
- rrPtr update:
  - At least one grant: rrPtr <= (index of last granted source + 1) mod NUM_SOURCES.
  - No grant: rrPtr unchanged.
  - Wrap-around: index NUM_SOURCES-1 granted last gives rrPtr=0.
- Starvation-free: any continuously valid source is granted within ceil(NUM_SOURCES/NUM_WRITE_PORTS)+1 cycles, provided its address does not keep colliding with a higher-priority source.
- No backpressure from the register file: write ports are always accepted.
- No valid sources: all srcReady=0; next cycle writeEnable=0 and grantCount=0.
- Reset mid-operation: in-flight registered writes are dropped (writeEnable forced 0 immediately, asynchronously); sources see srcReady=0.

Test Plan:
- Reset: assert rstN=0 mid-stream with writeEnable=4'b1111 -> writeEnable=0 immediately, grantCount=0; first grant after release starts at source 0.
- Single source: source 2 valid, addr=5, data=0xDEADBEEF -> srcReady=6'b000100 same cycle; next cycle writeEnable=4'b0001, port0 addr=5, data=0xDEADBEEF, grantCount=1.
- Oversubscription, round-robin: all 6 valid with addrs 1..6, rrPtr=0 -> cycle0 grants src0-3 (ports0-3 = regs 1-4), rrPtr=4. Cycle1 grants src4, src5, src0, src1, rrPtr=2. Src2 and src3 are granted in cycle2.
- Address collision: src0 and src1 both addr=7, rrPtr=0 -> only src0 ready; src1 granted next cycle. Never two enabled ports with addr 7 in one cycle.
- Register 0: src3 valid, addr=0, data=0x1234 -> srcReady[3]=1; next cycle writeEnable=0, grantCount=1.
- Wrap: rrPtr=5, src5 and src1 valid -> src5 on port0, src1 on port1; rrPtr becomes 2.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Result-channel handshake and register-file write-port bundle for writeback_arbiter.
// master = functional-unit/register-file side, slave = the arbiter.
interface writeback_arbiter_if #(
    parameter int unsigned REG_NUM         = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_WRITE_PORTS = 4,
    parameter int unsigned NUM_SOURCES     = 6
);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);
    localparam int unsigned CNT_W  = $clog2(NUM_WRITE_PORTS + 1);

    logic [NUM_SOURCES-1:0]                srcValid;
    logic [NUM_SOURCES*ADDR_W-1:0]         srcAddr;
    logic [NUM_SOURCES*DATA_WIDTH-1:0]     srcData;
    logic [NUM_SOURCES-1:0]                srcReady;
    logic [NUM_WRITE_PORTS-1:0]            writeEnable;
    logic [NUM_WRITE_PORTS*ADDR_W-1:0]     writeAddr;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] dataInputs;
    logic [CNT_W-1:0]                      grantCount;

    modport master (
        output srcValid, srcAddr, srcData,
        input  srcReady, writeEnable, writeAddr, dataInputs, grantCount
    );

    modport slave (
        input  srcValid, srcAddr, srcData,
        output srcReady, writeEnable, writeAddr, dataInputs, grantCount
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: accepts up to NUM_WRITE_PORTS results per cycle, never two
// enabled writes to the same register, never a write to r0, one register stage to the ports.
module writeback_arbiter #(
    parameter int unsigned REG_NUM         = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_WRITE_PORTS = 4,
    parameter int unsigned NUM_SOURCES     = 6
) (
    input logic               clk,
    input logic               rstN,
    writeback_arbiter_if.slave wb
);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);
    localparam int unsigned CNT_W  = $clog2(NUM_WRITE_PORTS + 1);
    localparam int unsigned PTR_W  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [PTR_W-1:0]                      rr_q, rr_d;
    logic [NUM_WRITE_PORTS-1:0]            we_q, we_d;
    logic [NUM_WRITE_PORTS*ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_SOURCES-1:0]                grant;
    int unsigned                           idx;
    int unsigned                           n;
    logic [ADDR_W-1:0]                     cur_addr;
    logic                                  hit;

    always_comb begin
        grant    = '0;
        we_d     = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        rr_d     = rr_q;
        idx      = 0;
        n        = 0;
        cur_addr = '0;
        hit      = 1'b0;
        for (int unsigned off = 0; off < NUM_SOURCES; off++) begin
            idx = 32'(rr_q) + off;
            if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
            cur_addr = wb.srcAddr[idx*ADDR_W +: ADDR_W];
            // Only enabled (nonzero-address) earlier grants block a later source.
            hit = 1'b0;
            for (int unsigned k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (we_d[k] && (addr_d[k*ADDR_W +: ADDR_W] == cur_addr)) hit = 1'b1;
            end
            if (wb.srcValid[idx] && (n < NUM_WRITE_PORTS) && !hit) begin
                grant[idx]                          = 1'b1;
                we_d[n]                             = (cur_addr != '0);
                addr_d[n*ADDR_W +: ADDR_W]          = cur_addr;
                data_d[n*DATA_WIDTH +: DATA_WIDTH]  = wb.srcData[idx*DATA_WIDTH +: DATA_WIDTH];
                n                                   = n + 1;
                rr_d = (idx == NUM_SOURCES - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        cnt_d = CNT_W'(n);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rr_q   <= '0;
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        wb.srcReady    = rstN ? grant : '0;
        wb.writeEnable = we_q;
        wb.writeAddr   = addr_q;
        wb.dataInputs  = data_q;
        wb.grantCount  = cnt_q;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based round-robin reference model.
module tb_writeback_arbiter;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned NWP     = 4;
    localparam int unsigned NS      = 6;
    localparam int unsigned AW      = $clog2(REG_NUM);
    localparam int unsigned CW      = $clog2(NWP + 1);

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if #(
        .REG_NUM(REG_NUM), .DATA_WIDTH(DW), .NUM_WRITE_PORTS(NWP), .NUM_SOURCES(NS)
    ) wb ();

    writeback_arbiter #(
        .REG_NUM(REG_NUM), .DATA_WIDTH(DW), .NUM_WRITE_PORTS(NWP), .NUM_SOURCES(NS)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .wb   (wb)
    );

    int total  = 0;
    int passed = 0;

    // Source-side state driven by the bench
    bit              s_valid[NS];
    logic [AW-1:0]   s_addr[NS];
    logic [DW-1:0]   s_data[NS];

    // Reference model
    int              rr_m;
    int              sel_q[$];
    logic [NS-1:0]   exp_ready;
    logic [NWP-1:0]  exp_we;
    logic [AW-1:0]   exp_addr[NWP];
    logic [DW-1:0]   exp_data[NWP];
    bit              known[NWP];
    int              exp_cnt;

    function automatic void model_reset();
        rr_m = 0;
        sel_q.delete();
        exp_ready = '0;
        exp_we = '0;
        exp_cnt = 0;
        for (int k = 0; k < NWP; k++) begin
            exp_addr[k] = '0;
            exp_data[k] = '0;
            known[k] = 1'b1;
        end
    endfunction

    // Walk one lap from rr_m; take valid sources until ports run out, skipping repeated
    // nonzero destinations.
    function automatic void model_select();
        bit taken[REG_NUM];
        sel_q.delete();
        exp_ready = '0;
        for (int r = 0; r < REG_NUM; r++) taken[r] = 1'b0;
        for (int off = 0; off < NS; off++) begin
            int i = (rr_m + off) % NS;
            int a = int'(s_addr[i]);
            if (s_valid[i] && sel_q.size() < NWP && !(a != 0 && taken[a])) begin
                sel_q.push_back(i);
                exp_ready[i] = 1'b1;
                if (a != 0) taken[a] = 1'b1;
            end
        end
    endfunction

    function automatic void model_commit();
        exp_we = '0;
        exp_cnt = sel_q.size();
        foreach (sel_q[k]) begin
            int i = sel_q[k];
            exp_we[k]   = (s_addr[i] != '0);
            exp_addr[k] = s_addr[i];
            exp_data[k] = s_data[i];
            known[k]    = (s_addr[i] != '0);
        end
        if (sel_q.size() > 0) rr_m = (sel_q[sel_q.size()-1] + 1) % NS;
    endfunction

    task automatic apply();
        for (int i = 0; i < NS; i++) begin
            wb.srcValid[i]             = s_valid[i];
            wb.srcAddr[i*AW +: AW]     = s_addr[i];
            wb.srcData[i*DW +: DW]     = s_data[i];
        end
        #1;
        model_select();
    endtask

    task automatic tick(input bit drop);
        @(posedge clk);
        model_commit();
        if (drop) begin
            for (int i = 0; i < NS; i++) if (exp_ready[i]) s_valid[i] = 1'b0;
        end
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            s_valid[i] = 1'b0;
            s_addr[i]  = '0;
            s_data[i]  = '0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NS; i++) begin
            s_valid[i] = 1'b1;
            s_addr[i]  = AW'(i + 1);
            s_data[i]  = $urandom;
        end
        apply();
        #2 rstN = 1'b0;
        #2;
        model_reset();
        total++;
        if (wb.srcReady !== '0) $display("FAIL reset_ready got %b want 0", wb.srcReady);
        else passed++;
        total++;
        if (wb.writeEnable !== '0 || wb.grantCount !== '0)
            $display("FAIL reset_we_cnt got we=%b cnt=%0d want 0/0", wb.writeEnable, wb.grantCount);
        else passed++;
        total++;
        if (wb.writeAddr !== '0 || wb.dataInputs !== '0)
            $display("FAIL reset_addr_data got %h/%h want 0", wb.writeAddr, wb.dataInputs);
        else passed++;
        clear_sources();
        apply();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        clear_sources();
        s_valid[2] = 1'b1;
        s_addr[2]  = AW'(5);
        s_data[2]  = 32'hDEADBEEF;
        apply();
        total++;
        if (wb.srcReady !== 6'b000100) $display("FAIL single_ready got %b want 000100", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== 4'b0001 || wb.grantCount !== CW'(1))
            $display("FAIL single_we got we=%b cnt=%0d want 0001/1", wb.writeEnable, wb.grantCount);
        else passed++;
        total++;
        if (wb.writeAddr[AW-1:0] !== AW'(5) || wb.dataInputs[DW-1:0] !== 32'hDEADBEEF)
            $display("FAIL single_port0 got %0d/%h want 5/deadbeef",
                     wb.writeAddr[AW-1:0], wb.dataInputs[DW-1:0]);
        else passed++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < NS; i++) begin
            s_valid[i] = 1'b1;
            s_addr[i]  = AW'(i + 1);
            s_data[i]  = $urandom;
        end
        apply();
        tick(1'b0);
        total++;
        if (wb.writeEnable !== 4'b1111)
            $display("FAIL midrst_pre got we=%b want 1111", wb.writeEnable);
        else passed++;
        rstN = 1'b0;
        #1;
        model_reset();
        total++;
        if (wb.writeEnable !== '0 || wb.grantCount !== '0 || wb.srcReady !== '0)
            $display("FAIL midrst_async got we=%b cnt=%0d rdy=%b want 0/0/0",
                     wb.writeEnable, wb.grantCount, wb.srcReady);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_oversub();
        logic [NS-1:0]     want_rdy[3];
        logic [NWP*AW-1:0] want_addr[3];
        want_rdy[0]  = 6'b001111;
        want_rdy[1]  = 6'b110011;
        want_rdy[2]  = 6'b111100;
        want_addr[0] = {5'd4, 5'd3, 5'd2, 5'd1};
        want_addr[1] = {5'd2, 5'd1, 5'd6, 5'd5};
        want_addr[2] = {5'd6, 5'd5, 5'd4, 5'd3};
        for (int c = 0; c < 3; c++) begin
            apply();
            total++;
            if (wb.srcReady !== want_rdy[c] || exp_ready !== want_rdy[c])
                $display("FAIL oversub_ready[%0d] got %b model %b want %b",
                         c, wb.srcReady, exp_ready, want_rdy[c]);
            else passed++;
            tick(1'b0);
            total++;
            if (wb.writeEnable !== 4'b1111 || wb.writeAddr !== want_addr[c])
                $display("FAIL oversub_ports[%0d] got we=%b addr=%h want 1111/%h",
                         c, wb.writeEnable, wb.writeAddr, want_addr[c]);
            else passed++;
        end
        clear_sources();
    endtask

    task automatic test_collision();
        clear_sources();
        s_valid[0] = 1'b1; s_addr[0] = AW'(7); s_data[0] = 32'h0000_0A0A;
        s_valid[1] = 1'b1; s_addr[1] = AW'(7); s_data[1] = 32'h0000_0B0B;
        apply();
        total++;
        if (wb.srcReady !== 6'b000001) $display("FAIL coll_ready0 got %b want 000001", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== 4'b0001 || wb.writeAddr[AW-1:0] !== AW'(7)
            || wb.dataInputs[DW-1:0] !== 32'h0000_0A0A)
            $display("FAIL coll_port0 got we=%b addr=%0d data=%h want 0001/7/a0a",
                     wb.writeEnable, wb.writeAddr[AW-1:0], wb.dataInputs[DW-1:0]);
        else passed++;
        apply();
        total++;
        if (wb.srcReady !== 6'b000010) $display("FAIL coll_ready1 got %b want 000010", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== 4'b0001 || wb.dataInputs[DW-1:0] !== 32'h0000_0B0B)
            $display("FAIL coll_retry got we=%b data=%h want 0001/b0b",
                     wb.writeEnable, wb.dataInputs[DW-1:0]);
        else passed++;
    endtask

    task automatic test_reg0();
        clear_sources();
        s_valid[3] = 1'b1; s_addr[3] = '0; s_data[3] = 32'h1234;
        apply();
        total++;
        if (wb.srcReady !== 6'b001000) $display("FAIL reg0_ready got %b want 001000", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== '0 || wb.grantCount !== CW'(1))
            $display("FAIL reg0_out got we=%b cnt=%0d want 0000/1", wb.writeEnable, wb.grantCount);
        else passed++;
    endtask

    task automatic test_wrap();
        clear_sources();
        s_valid[4] = 1'b1; s_addr[4] = AW'(9); s_data[4] = 32'h9;
        apply();
        tick(1'b1);
        s_valid[5] = 1'b1; s_addr[5] = AW'(10); s_data[5] = 32'hA;
        s_valid[1] = 1'b1; s_addr[1] = AW'(11); s_data[1] = 32'hB;
        apply();
        total++;
        if (wb.srcReady !== 6'b100010) $display("FAIL wrap_ready got %b want 100010", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== 4'b0011 || wb.writeAddr[2*AW-1:0] !== {5'd11, 5'd10})
            $display("FAIL wrap_ports got we=%b addr=%h want 0011/{11,10}",
                     wb.writeEnable, wb.writeAddr[2*AW-1:0]);
        else passed++;
        // Pointer should now sit at 2, so src2 takes port 0 ahead of src1.
        s_valid[1] = 1'b1; s_addr[1] = AW'(12); s_data[1] = 32'hC;
        s_valid[2] = 1'b1; s_addr[2] = AW'(13); s_data[2] = 32'hD;
        apply();
        tick(1'b1);
        total++;
        if (wb.writeAddr[2*AW-1:0] !== {5'd12, 5'd13})
            $display("FAIL wrap_ptr got addr=%h want {12,13}", wb.writeAddr[2*AW-1:0]);
        else passed++;
    endtask

    task automatic test_idle();
        clear_sources();
        apply();
        total++;
        if (wb.srcReady !== '0) $display("FAIL idle_ready got %b want 0", wb.srcReady);
        else passed++;
        tick(1'b1);
        total++;
        if (wb.writeEnable !== '0 || wb.grantCount !== '0)
            $display("FAIL idle_out got we=%b cnt=%0d want 0/0", wb.writeEnable, wb.grantCount);
        else passed++;
        for (int k = 0; k < NWP; k++) begin
            if (known[k]) begin
                total++;
                if (wb.writeAddr[k*AW +: AW] !== exp_addr[k] || wb.dataInputs[k*DW +: DW] !== exp_data[k])
                    $display("FAIL idle_hold[%0d] got %0d/%h want %0d/%h", k,
                             wb.writeAddr[k*AW +: AW], wb.dataInputs[k*DW +: DW],
                             exp_addr[k], exp_data[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit bad;
            for (int i = 0; i < NS; i++) begin
                if (!s_valid[i] && $urandom_range(0, 9) < 6) begin
                    s_valid[i] = 1'b1;
                    s_addr[i]  = AW'($urandom_range(0, 7));
                    s_data[i]  = $urandom;
                end
            end
            apply();
            total++;
            if (wb.srcReady !== exp_ready)
                $display("FAIL rand_ready[%0d] got %b want %b", c, wb.srcReady, exp_ready);
            else passed++;
            tick(1'b1);
            total++;
            if (wb.writeEnable !== exp_we || wb.grantCount !== CW'(exp_cnt))
                $display("FAIL rand_we[%0d] got we=%b cnt=%0d want %b/%0d",
                         c, wb.writeEnable, wb.grantCount, exp_we, exp_cnt);
            else passed++;
            for (int k = 0; k < NWP; k++) begin
                if (known[k]) begin
                    total++;
                    if (wb.writeAddr[k*AW +: AW] !== exp_addr[k]
                        || wb.dataInputs[k*DW +: DW] !== exp_data[k])
                        $display("FAIL rand_port[%0d][%0d] got %0d/%h want %0d/%h", c, k,
                                 wb.writeAddr[k*AW +: AW], wb.dataInputs[k*DW +: DW],
                                 exp_addr[k], exp_data[k]);
                    else passed++;
                end
            end
            bad = 1'b0;
            for (int j = 0; j < NWP; j++) begin
                if (wb.writeEnable[j] && wb.writeAddr[j*AW +: AW] == '0) bad = 1'b1;
                for (int k = j + 1; k < NWP; k++)
                    if (wb.writeEnable[j] && wb.writeEnable[k]
                        && wb.writeAddr[j*AW +: AW] == wb.writeAddr[k*AW +: AW]) bad = 1'b1;
            end
            total++;
            if (bad) $display("FAIL rand_unique[%0d] got we=%b addr=%h want distinct nonzero",
                              c, wb.writeEnable, wb.writeAddr);
            else passed++;
        end
    endtask

    initial begin
        clear_sources();
        wb.srcValid = '0;
        wb.srcAddr  = '0;
        wb.srcData  = '0;
        test_reset();
        test_single();
        test_mid_reset();
        test_oversub();
        test_collision();
        test_reg0();
        test_wrap();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
